// File: rtl/collatz_range_par.sv
// Multi-lane Collatz range engine: LANES iterators fill a RAM_WORDS result RAM per go.
// Optional max tracking (max_count/max_addr) is enabled by defining COLLATZ_RANGE_MAXTRACK_EN.
module collatz_range_par #(
   parameter int RAM_WORDS     = 16,
   parameter int RAM_ADDR_BITS = 4,
   parameter int LANES         = 4,
   parameter int N_BITS        = 32,
   parameter int COUNT_BITS    = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     go,
   input  logic [N_BITS-1:0]        start,
   output logic                     busy,
   output logic                     done,
   output logic                     ovf,
   output logic [COUNT_BITS-1:0]    count
`ifdef COLLATZ_RANGE_MAXTRACK_EN
   ,
   output logic [COUNT_BITS-1:0]    max_count,
   output logic [RAM_ADDR_BITS-1:0] max_addr
`endif
);

   localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CTR_BITS  = RAM_ADDR_BITS + 1;
   localparam logic [CTR_BITS-1:0]   CTR_ONE  = 1;
   localparam logic [CTR_BITS-1:0]   CTR_LAST = CTR_BITS'(RAM_WORDS - 1);
   localparam logic [CTR_BITS-1:0]   CTR_FULL = CTR_BITS'(RAM_WORDS);
   localparam logic [N_BITS-1:0]     N_ONE    = 1;
   localparam logic [N_BITS+1:0]     W_ONE    = 1;
   localparam logic [COUNT_BITS-1:0] CNT_ONE  = 1;
   localparam logic [COUNT_BITS-1:0] CNT_OVF  = '1;
   localparam logic [COUNT_BITS-1:0] CNT_MAX  = CNT_OVF - CNT_ONE;

   logic [COUNT_BITS-1:0] mem [RAM_WORDS];

   logic [N_BITS-1:0]   base;
   logic [N_BITS-1:0]   next_n;
   logic [CTR_BITS-1:0] issued;
   logic [CTR_BITS-1:0] written;

   logic [LANES-1:0]      lane_run;
   logic [LANES-1:0]      lane_fin;
   logic [N_BITS-1:0]     lane_cur [LANES];
   logic [N_BITS-1:0]     lane_n   [LANES];
   logic [COUNT_BITS-1:0] lane_cnt [LANES];

   logic [N_BITS+1:0]     tri3     [LANES];
   logic [N_BITS-1:0]     step_cur [LANES];
   logic [COUNT_BITS-1:0] step_cnt [LANES];
   logic [LANES-1:0]      step_fin;
   logic [LANES-1:0]      step_ovf;

   logic                     iss_ok;
   logic [LANE_BITS-1:0]     iss_idx;
   logic                     wr_en;
   logic [LANE_BITS-1:0]     wr_idx;
   logic [RAM_ADDR_BITS-1:0] wr_addr;
   logic [COUNT_BITS-1:0]    wr_data;

   // One Collatz step per running lane; the 2 extra bits of tri3 catch 3n+1 carry-out.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         tri3[i]     = ({2'b00, lane_cur[i]} << 1) + {2'b00, lane_cur[i]} + W_ONE;
         step_cur[i] = lane_cur[i];
         step_cnt[i] = (lane_cnt[i] < CNT_MAX) ? lane_cnt[i] + CNT_ONE : lane_cnt[i];
         step_fin[i] = 1'b0;
         step_ovf[i] = 1'b0;
         if (lane_cur[i] == '0) begin
            step_fin[i] = 1'b1;
            step_cnt[i] = '0;
         end else if (lane_cur[i] == N_ONE) begin
            step_fin[i] = 1'b1;
            step_cnt[i] = lane_cnt[i];
         end else if (!lane_cur[i][0]) begin
            step_cur[i] = lane_cur[i] >> 1;
         end else if (tri3[i][N_BITS+1:N_BITS] != 2'b00) begin
            step_fin[i] = 1'b1;
            step_ovf[i] = 1'b1;
            step_cnt[i] = CNT_OVF;
         end else begin
            step_cur[i] = tri3[i][N_BITS-1:0];
         end
      end
   end

   // Lowest-index idle lane takes the next number; lowest-index finished lane owns the write port.
   always_comb begin
      iss_ok  = 1'b0;
      iss_idx = '0;
      wr_en   = 1'b0;
      wr_idx  = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (!lane_run[i] && !lane_fin[i]) begin
            iss_ok  = 1'b1;
            iss_idx = LANE_BITS'(i);
         end
         if (lane_fin[i]) begin
            wr_en  = 1'b1;
            wr_idx = LANE_BITS'(i);
         end
      end
      iss_ok  = iss_ok && busy && (issued != CTR_FULL);
      wr_en   = wr_en && busy;
      wr_addr = RAM_ADDR_BITS'(lane_n[wr_idx] - base);
      wr_data = lane_cnt[wr_idx];
   end

   // go/busy handshake: go is taken only in a cycle where busy=0 (including the done cycle);
   // busy rises the next cycle and stays high until the final result is written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         count    <= '0;
         base     <= '0;
         next_n   <= '0;
         issued   <= '0;
         written  <= '0;
         lane_run <= '0;
         lane_fin <= '0;
         for (int i = 0; i < LANES; i++) begin
            lane_cur[i] <= '0;
            lane_n[i]   <= '0;
            lane_cnt[i] <= '0;
         end
      end else begin
         done  <= 1'b0;
         count <= mem[start[RAM_ADDR_BITS-1:0]];
         if (go && !busy) begin
            busy    <= 1'b1;
            base    <= start;
            next_n  <= start;
            ovf     <= 1'b0;
            issued  <= '0;
            written <= '0;
         end
         for (int i = 0; i < LANES; i++) begin
            if (lane_run[i]) begin
               lane_cur[i] <= step_cur[i];
               lane_cnt[i] <= step_cnt[i];
               if (step_fin[i]) begin
                  lane_run[i] <= 1'b0;
                  lane_fin[i] <= 1'b1;
               end
               if (step_ovf[i]) ovf <= 1'b1;
            end
         end
         if (iss_ok) begin
            lane_run[iss_idx] <= 1'b1;
            lane_cur[iss_idx] <= next_n;
            lane_n[iss_idx]   <= next_n;
            lane_cnt[iss_idx] <= CNT_ONE;
            next_n            <= next_n + N_ONE;
            issued            <= issued + CTR_ONE;
         end
         if (wr_en) begin
            lane_fin[wr_idx] <= 1'b0;
            written          <= written + CTR_ONE;
            if (written == CTR_LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

`ifdef COLLATZ_RANGE_MAXTRACK_EN
   // Ties resolve to the lower address so the result is independent of lane write order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_count <= '0;
         max_addr  <= '0;
      end else if (go && !busy) begin
         max_count <= '0;
         max_addr  <= '0;
      end else if (wr_en && (wr_data != CNT_OVF) &&
                   ((wr_data > max_count) || ((wr_data == max_count) && (wr_addr < max_addr)))) begin
         max_count <= wr_data;
         max_addr  <= wr_addr;
      end
   end
`endif

endmodule

// File: tb/tb_collatz_range_par.sv
// Bench for collatz_range_par: three instances (LANES=4/1/16) driven in lockstep,
// table vectors for known sequences plus random runs against a plain-arithmetic model.
module tb_collatz_range_par;

   logic        clk;
   logic        reset_n;
   logic        go;
   logic [31:0] start;

   logic        busy4, done4, ovf4;
   logic        busy1, done1, ovf1;
   logic        busy16, done16, ovf16;
   logic [15:0] count4, count1, count16;
`ifdef COLLATZ_RANGE_MAXTRACK_EN
   logic [15:0] max_count4, max_count1, max_count16;
   logic [3:0]  max_addr4, max_addr1, max_addr16;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] s;
      int          addr;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs [21];
   logic [15:0] t1 [16] = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
                            16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};
   logic [15:0] exp_w [16];
   logic        exp_ovf;
   logic [15:0] exp_max;
   logic [3:0]  exp_max_addr;

   collatz_range_par #(.LANES(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .go(go), .start(start),
      .busy(busy4), .done(done4), .ovf(ovf4), .count(count4)
`ifdef COLLATZ_RANGE_MAXTRACK_EN
      , .max_count(max_count4), .max_addr(max_addr4)
`endif
   );

   collatz_range_par #(.LANES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .go(go), .start(start),
      .busy(busy1), .done(done1), .ovf(ovf1), .count(count1)
`ifdef COLLATZ_RANGE_MAXTRACK_EN
      , .max_count(max_count1), .max_addr(max_addr1)
`endif
   );

   collatz_range_par #(.LANES(16)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .go(go), .start(start),
      .busy(busy16), .done(done16), .ovf(ovf16), .count(count16)
`ifdef COLLATZ_RANGE_MAXTRACK_EN
      , .max_count(max_count16), .max_addr(max_addr16)
`endif
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference: terms from n down to 1 inclusive, computed in 64-bit arithmetic
   function automatic logic [15:0] ref_len(input logic [31:0] n0);
      longint unsigned n;
      int unsigned     c;
      n = 64'(n0);
      if (n == 0) return 16'h0000;
      c = 1;
      while (n != 1) begin
         if (n % 2 == 0) n = n / 2;
         else begin
            n = 3 * n + 1;
            if (n > 64'hFFFF_FFFF) return 16'hFFFF;
         end
         if (c < 65534) c++;
      end
      return 16'(c);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic build_model(input logic [31:0] s);
      exp_ovf      = 1'b0;
      exp_max      = 16'h0;
      exp_max_addr = 4'h0;
      for (int a = 0; a < 16; a++) begin
         exp_w[a] = ref_len(s + 32'(a));
         if (exp_w[a] == 16'hFFFF) exp_ovf = 1'b1;
         else if (exp_w[a] > exp_max) begin
            exp_max      = exp_w[a];
            exp_max_addr = 4'(a);
         end
      end
   endtask

   // one run on all three instances, with extra go pulses while busy that must be ignored
   task automatic do_run(input logic [31:0] s);
      int cyc;
      int p4, p1, p16;
      build_model(s);
      @(negedge clk);
      start = s;
      go    = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk("busy_after_go_l4", 32'(busy4), 32'd1);
      chk("busy_after_go_l1", 32'(busy1), 32'd1);
      chk("busy_after_go_l16", 32'(busy16), 32'd1);
      start = $urandom;
      repeat (6) begin
         @(negedge clk);
         go    = 1'($urandom_range(0, 1));
         start = $urandom;
      end
      @(negedge clk);
      go  = 1'b0;
      cyc = 0;
      p4  = 0;
      p1  = 0;
      p16 = 0;
      while (cyc < 60000) begin
         if (done4) begin
            p4++;
            chk("busy_low_at_done", 32'(busy4), 32'd0);
         end
         if (done1) p1++;
         if (done16) p16++;
         if (!busy4 && !busy1 && !busy16) break;
         @(negedge clk);
         cyc++;
      end
      chk("run_completed_in_budget", 32'(cyc < 60000), 32'd1);
      chk("done_pulses_l4", 32'(p4), 32'd1);
      chk("done_pulses_l1", 32'(p1), 32'd1);
      chk("done_pulses_l16", 32'(p16), 32'd1);
      chk("ovf_l4", 32'(ovf4), 32'(exp_ovf));
      chk("ovf_l1", 32'(ovf1), 32'(exp_ovf));
      chk("ovf_l16", 32'(ovf16), 32'(exp_ovf));
`ifdef COLLATZ_RANGE_MAXTRACK_EN
      chk("max_count_l4", 32'(max_count4), 32'(exp_max));
      chk("max_addr_l4", 32'(max_addr4), 32'(exp_max_addr));
      chk("max_count_l1", 32'(max_count1), 32'(exp_max));
      chk("max_addr_l16", 32'(max_addr16), 32'(exp_max_addr));
`endif
   endtask

   task automatic read_chk(input int addr, input logic [15:0] exp, input string tag);
      @(negedge clk);
      start = 32'(addr);
      @(negedge clk);
      chk($sformatf("%s_l4_a%0d", tag, addr), 32'(count4), 32'(exp));
      chk($sformatf("%s_l1_a%0d", tag, addr), 32'(count1), 32'(exp));
      chk($sformatf("%s_l16_a%0d", tag, addr), 32'(count16), 32'(exp));
   endtask

   initial begin
      logic [31:0] last_s;
      bit          have_run;
      logic [31:0] rs;

      for (int a = 0; a < 16; a++) vecs[a] = '{32'd1, a, t1[a]};
      vecs[16] = '{32'd0, 0, 16'd0};
      vecs[17] = '{32'd0, 1, 16'd1};
      vecs[18] = '{32'd0, 2, 16'd2};
      vecs[19] = '{32'd0, 3, 16'd8};
      vecs[20] = '{32'hFFFF_FFFF, 0, 16'hFFFF};

      // reset
      reset_n = 1'b0;
      go      = 1'b0;
      start   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy4), 32'd0);
      chk("reset_done", 32'(done4), 32'd0);
      chk("reset_ovf", 32'(ovf4), 32'd0);
      chk("reset_count", 32'(count4), 32'd0);
      reset_n = 1'b1;

      // table vectors: known sequences, start=0 and start=all-ones corners
      have_run = 1'b0;
      last_s   = '0;
      for (int k = 0; k < 21; k++) begin
         if (!have_run || vecs[k].s != last_s) begin
            do_run(vecs[k].s);
            have_run = 1'b1;
            last_s   = vecs[k].s;
         end
         read_chk(vecs[k].addr, vecs[k].exp, "vec");
      end
`ifdef COLLATZ_RANGE_MAXTRACK_EN
      // start=1 run again just for the fixed max expectations
      do_run(32'd1);
      chk("max_count_fixed", 32'(max_count4), 32'd20);
      chk("max_addr_fixed", 32'(max_addr4), 32'd8);
      do_run(32'hFFFF_FFFF);
`endif
      chk("ovf_sticky_idle", 32'(ovf4), 32'd1);
      // next go clears ovf
      do_run(32'd1);
      chk("ovf_cleared_by_go", 32'(ovf4), 32'd0);

      // asynchronous reset mid-run
      @(negedge clk);
      start = 32'hFFFF_FFFF;
      go    = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      chk("ovf_midrun", 32'(ovf4), 32'd1);
      chk("busy_midrun", 32'(busy4), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy_l4", 32'(busy4), 32'd0);
      chk("async_rst_done_l4", 32'(done4), 32'd0);
      chk("async_rst_ovf_l4", 32'(ovf4), 32'd0);
      chk("async_rst_busy_l1", 32'(busy1), 32'd0);
      chk("async_rst_ovf_l1", 32'(ovf1), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      do_run(32'd1);
      for (int a = 0; a < 16; a++) read_chk(a, t1[a], "after_rst");

      // random runs against the model
      for (int r = 0; r < 4; r++) begin
         rs = (r == 3) ? $urandom : 32'($urandom_range(2, 1 << 20));
         do_run(rs);
         for (int a = 0; a < 16; a++) read_chk(a, exp_w[a], "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
